char_row_renderer: RTL and testbench

- Sequences the per-scanline rendering datapath.
- For each of COLS character cells it:
  - reads a 16-bit code/attribute word from the character row buffer;
  - reads the 8-pixel font pattern from font memory;
  - reads the foreground and background colours from the palette (two sequential reads);
  - writes 8 pixels to the pixel buffer.
- Sits between the timing generator (which pulses start once per scanline, ahead of the back porch end) and the chrowbuf/fontmem/palette/pixbuf memories.
- Fetch of cell n+1 overlaps emission of cell n, so steady-state output is one pixel per clock.

---
 rtl/char_row_renderer.sv | 193 +++++++++++++++++++
 tb/tb_char_row_renderer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_row_renderer.sv
// Scanline renderer: fetches COLS code/attribute cells and streams 8 pixels per cell to the pixel buffer.
// Optional cursor inversion (fg/bg swap on one column) is enabled by defining RENDER_CURSOR_EN.
module char_row_renderer #(
  parameter int COLS     = 100,
  parameter int PIX_BASE = 0,
  parameter int PIX_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        font_row,
  output logic              busy,
  output logic              done,
  output logic              chrowbuf_rd_n,
  output logic [7:0]        chrowbuf_rd_addr,
  input  logic [15:0]       chrowbuf_rd_data,
  output logic              fontmem_rd_n,
  output logic [11:0]       fontmem_rd_addr,
  input  logic [7:0]        fontmem_rd_data,
  output logic              palette_rd_n,
  output logic [7:0]        palette_rd_addr,
  input  logic [15:0]       palette_rd_data,
  output logic              pixbuf_wr_n,
  output logic [PIX_AW-1:0] pixbuf_wr_addr,
  output logic [15:0]       pixbuf_wr_data
`ifdef RENDER_CURSOR_EN
  ,
  input  logic              cursor_on,
  input  logic [7:0]        cursor_col
`endif
);

  // Handshake between the two FSMs: the fetch side raises next_valid when a
  // complete cell (pattern, fg, bg, column) sits in the next_* registers; the
  // emitter takes it with emit_load, which clears next_valid on the same edge.
  typedef enum logic [2:0] {
    F_IDLE, S_CH, S_FONT, S_BG, S_PUT, S_WAIT
  } fetch_state_t;

  typedef enum logic {
    E_IDLE, E_RUN
  } emit_state_t;

  localparam logic [7:0]        LAST_COL = 8'(COLS - 1);
  localparam logic [PIX_AW-1:0] BASE_A   = PIX_AW'(PIX_BASE);

  fetch_state_t f_state;
  emit_state_t  e_state;

  logic [7:0]  fetch_col;
  logic [3:0]  row_q;
  logic [3:0]  bg_idx;
  logic [7:0]  next_pat;
  logic [15:0] next_fg;
  logic [15:0] next_bg;
  logic [7:0]  next_col;
  logic        next_valid;

  logic [2:0]  k;
  logic [7:0]  cur_pat;
  logic [15:0] cur_fg;
  logic [15:0] cur_bg;
  logic [7:0]  emit_col;

  logic start_ok;
  logic emit_load;
  logic swap;

  assign start_ok  = start && (f_state == F_IDLE) && !busy;
  assign emit_load = next_valid && ((e_state == E_IDLE) || (k == 3'd7));

`ifdef RENDER_CURSOR_EN
  logic       cursor_on_q;
  logic [7:0] cursor_col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_on_q  <= 1'b0;
      cursor_col_q <= 8'd0;
    end else if (start_ok) begin
      cursor_on_q  <= cursor_on;
      cursor_col_q <= cursor_col;
    end
  end

  // Columns never exceed COLS-1, so an out-of-range cursor_col simply never matches.
  assign swap = cursor_on_q && (next_col == cursor_col_q);
`else
  assign swap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state    <= F_IDLE;
      fetch_col  <= 8'd0;
      row_q      <= 4'd0;
      bg_idx     <= 4'd0;
      next_pat   <= 8'd0;
      next_fg    <= 16'd0;
      next_bg    <= 16'd0;
      next_col   <= 8'd0;
      next_valid <= 1'b0;
    end else begin
      if (emit_load) next_valid <= 1'b0;
      case (f_state)
        F_IDLE: begin
          if (start_ok) begin
            row_q     <= font_row;
            fetch_col <= 8'd0;
            f_state   <= S_CH;
          end
        end
        S_CH:   f_state <= S_FONT;
        S_FONT: begin
          bg_idx  <= chrowbuf_rd_data[15:12];
          f_state <= S_BG;
        end
        S_BG: begin
          next_pat <= fontmem_rd_data;
          next_fg  <= palette_rd_data;
          f_state  <= S_PUT;
        end
        S_PUT: begin
          // Placed after the consume clear so a same-cycle consume still lands the new cell.
          next_bg    <= palette_rd_data;
          next_col   <= fetch_col;
          next_valid <= 1'b1;
          fetch_col  <= fetch_col + 8'd1;
          f_state    <= (fetch_col == LAST_COL) ? F_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (!next_valid || emit_load) f_state <= S_CH;
        end
        default: f_state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_state  <= E_IDLE;
      k        <= 3'd0;
      cur_pat  <= 8'd0;
      cur_fg   <= 16'd0;
      cur_bg   <= 16'd0;
      emit_col <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) busy <= 1'b1;
      if (emit_load) begin
        e_state  <= E_RUN;
        k        <= 3'd0;
        cur_pat  <= next_pat;
        cur_fg   <= swap ? next_bg : next_fg;
        cur_bg   <= swap ? next_fg : next_bg;
        emit_col <= next_col;
      end else if (e_state == E_RUN) begin
        if (k == 3'd7) begin
          e_state <= E_IDLE;
          k       <= 3'd0;
          if (emit_col == LAST_COL) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end else begin
          k <= k + 3'd1;
        end
      end
    end
  end

  // {emit_col, k} is 8*col + k; the PIX_AW-wide add wraps modulo the buffer size.
  always_comb begin
    chrowbuf_rd_n    = (f_state != S_CH);
    chrowbuf_rd_addr = (f_state == S_CH) ? fetch_col : 8'd0;
    fontmem_rd_n     = (f_state != S_FONT);
    fontmem_rd_addr  = (f_state == S_FONT) ? {chrowbuf_rd_data[7:0], row_q} : 12'd0;
    palette_rd_n     = !((f_state == S_FONT) || (f_state == S_BG));
    palette_rd_addr  = 8'd0;
    if (f_state == S_FONT)    palette_rd_addr = {4'd0, chrowbuf_rd_data[11:8]};
    else if (f_state == S_BG) palette_rd_addr = {4'd0, bg_idx};
    pixbuf_wr_n    = (e_state != E_RUN);
    pixbuf_wr_addr = '0;
    pixbuf_wr_data = 16'd0;
    if (e_state == E_RUN) begin
      pixbuf_wr_addr = BASE_A + PIX_AW'({emit_col, k});
      pixbuf_wr_data = cur_pat[3'd7 - k] ? cur_fg : cur_bg;
    end
  end

endmodule

// File: tb/tb_char_row_renderer.sv
// Bench for char_row_renderer: a 100-column instance at base 0 and a 2-column instance at base 1020,
// both backed by shared behavioural chrowbuf/fontmem/palette arrays.
module tb_char_row_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  font_row = 4'd0;
  logic        busy, done;
  logic        chrowbuf_rd_n, fontmem_rd_n, palette_rd_n, pixbuf_wr_n;
  logic [7:0]  chrowbuf_rd_addr, palette_rd_addr;
  logic [11:0] fontmem_rd_addr;
  logic [15:0] chrow_q, pal_q, pixbuf_wr_data;
  logic [7:0]  font_q;
  logic [9:0]  pixbuf_wr_addr;
  logic        cursor_on = 1'b0;
  logic [7:0]  cursor_col = 8'd0;

  logic        start_b = 1'b0;
  logic [3:0]  font_row_b = 4'd0;
  logic        busy_b, done_b;
  logic        chrowbuf_rd_n_b, fontmem_rd_n_b, palette_rd_n_b, pixbuf_wr_n_b;
  logic [7:0]  chrowbuf_rd_addr_b, palette_rd_addr_b;
  logic [11:0] fontmem_rd_addr_b;
  logic [15:0] chrow_q_b, pal_q_b, pixbuf_wr_data_b;
  logic [7:0]  font_q_b;
  logic [9:0]  pixbuf_wr_addr_b;

  logic [15:0] chrow [256];
  logic [7:0]  font [4096];
  logic [15:0] pal [256];

  logic [25:0] exp_q[$];
  logic [25:0] exp_b_q[$];
  logic [15:0] wr_log [1024];
  int          wr_idx = 0;
  int          rd_col = 0;
  int          errors = 0;
  int          checks = 0;

  char_row_renderer dut (
    .clk(clk), .rst(rst), .start(start), .font_row(font_row), .busy(busy), .done(done),
    .chrowbuf_rd_n(chrowbuf_rd_n), .chrowbuf_rd_addr(chrowbuf_rd_addr), .chrowbuf_rd_data(chrow_q),
    .fontmem_rd_n(fontmem_rd_n), .fontmem_rd_addr(fontmem_rd_addr), .fontmem_rd_data(font_q),
    .palette_rd_n(palette_rd_n), .palette_rd_addr(palette_rd_addr), .palette_rd_data(pal_q),
    .pixbuf_wr_n(pixbuf_wr_n), .pixbuf_wr_addr(pixbuf_wr_addr), .pixbuf_wr_data(pixbuf_wr_data)
`ifdef RENDER_CURSOR_EN
    , .cursor_on(cursor_on), .cursor_col(cursor_col)
`endif
  );

  char_row_renderer #(.COLS(2), .PIX_BASE(1020), .PIX_AW(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .font_row(font_row_b), .busy(busy_b), .done(done_b),
    .chrowbuf_rd_n(chrowbuf_rd_n_b), .chrowbuf_rd_addr(chrowbuf_rd_addr_b), .chrowbuf_rd_data(chrow_q_b),
    .fontmem_rd_n(fontmem_rd_n_b), .fontmem_rd_addr(fontmem_rd_addr_b), .fontmem_rd_data(font_q_b),
    .palette_rd_n(palette_rd_n_b), .palette_rd_addr(palette_rd_addr_b), .palette_rd_data(pal_q_b),
    .pixbuf_wr_n(pixbuf_wr_n_b), .pixbuf_wr_addr(pixbuf_wr_addr_b), .pixbuf_wr_data(pixbuf_wr_data_b)
`ifdef RENDER_CURSOR_EN
    , .cursor_on(1'b0), .cursor_col(8'd0)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory models: data valid the cycle after a low strobe
  always @(posedge clk) begin
    if (chrowbuf_rd_n === 1'b0)   chrow_q   <= chrow[chrowbuf_rd_addr];
    if (fontmem_rd_n === 1'b0)    font_q    <= font[fontmem_rd_addr];
    if (palette_rd_n === 1'b0)    pal_q     <= pal[palette_rd_addr];
    if (chrowbuf_rd_n_b === 1'b0) chrow_q_b <= chrow[chrowbuf_rd_addr_b];
    if (fontmem_rd_n_b === 1'b0)  font_q_b  <= font[fontmem_rd_addr_b];
    if (palette_rd_n_b === 1'b0)  pal_q_b   <= pal[palette_rd_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel: {addr[9:0], colour[15:0]}
  function automatic logic [25:0] exp_pix(input int base, input int c, input int k, input logic [3:0] fr);
    logic [15:0] w, fg, bg, t;
    logic [7:0]  pat;
    logic [9:0]  a;
    w   = chrow[c];
    pat = font[{w[7:0], fr}];
    fg  = pal[{4'd0, w[11:8]}];
    bg  = pal[{4'd0, w[15:12]}];
`ifdef RENDER_CURSOR_EN
    if (cursor_on && (c == int'(cursor_col))) begin
      t = fg; fg = bg; bg = t;
    end
`else
    t = 16'd0;
`endif
    a = 10'((base + 8 * c + k) % 1024);
    return {a, pat[7 - k] ? fg : bg};
  endfunction

  // Scoreboard for both instances plus read-order tracking
  always @(negedge clk) begin
    logic [25:0] e;
    if (pixbuf_wr_n === 1'b0) begin
      if (wr_idx < 1024) wr_log[wr_idx] = pixbuf_wr_data;
      wr_idx++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_a", {22'd0, pixbuf_wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pix_addr_a", {22'd0, pixbuf_wr_addr}, {22'd0, e[25:16]});
        chk("pix_data_a", {16'd0, pixbuf_wr_data}, {16'd0, e[15:0]});
      end
    end
    if (chrowbuf_rd_n === 1'b0) begin
      chk("chrow_rd_order", {24'd0, chrowbuf_rd_addr}, rd_col);
      rd_col++;
    end
    if (pixbuf_wr_n_b === 1'b0) begin
      if (exp_b_q.size() == 0) begin
        chk("unexpected_write_b", {22'd0, pixbuf_wr_addr_b}, 32'hFFFF_FFFF);
      end else begin
        e = exp_b_q.pop_front();
        chk("pix_addr_b", {22'd0, pixbuf_wr_addr_b}, {22'd0, e[25:16]});
        chk("pix_data_b", {16'd0, pixbuf_wr_data_b}, {16'd0, e[15:0]});
      end
    end
  end

  // Driver: one start pulse on instance A, expected line queued at the same time
  task automatic start_a(input logic [3:0] fr);
    @(negedge clk);
    font_row = fr;
    start    = 1'b1;
    rd_col   = 0;
    wr_idx   = 0;
    for (int c = 0; c < 100; c++)
      for (int k = 0; k < 8; k++)
        exp_q.push_back(exp_pix(0, c, k, fr));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_line(input int restart_at, input int abort_at);
    int  n = 1;
    int  cnt = 0;
    bit  seen_done = 0;
    while (pixbuf_wr_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_write_cycle", n, 6);
    while (pixbuf_wr_n === 1'b0 && cnt < 900) begin
      cnt++;
      start = (cnt == restart_at);
      if (abort_at > 0 && cnt == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_n", pixbuf_wr_n, 1);
        chk("abort_chrow_n", chrowbuf_rd_n, 1);
        chk("abort_font_n", fontmem_rd_n, 1);
        chk("abort_pal_n", palette_rd_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (done !== 1'b0 || pixbuf_wr_n !== 1'b1) seen_done = 1;
        end
        chk("quiet_after_abort", seen_done, 0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("write_count", cnt, 800);
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    chk("reads_issued", rd_col, 100);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic setup_basic();
    for (int c = 0; c < 256; c++) chrow[c] = 16'h2141;
    font[12'h413] = 8'hA5;
    pal[1] = 16'h0FF0;
    pal[2] = 16'h0006;
  endtask

  initial begin
    logic [15:0] cell_tbl [8];
    int n;
    int cnt;
    cell_tbl = '{16'h0FF0, 16'h0006, 16'h0FF0, 16'h0006, 16'h0006, 16'h0FF0, 16'h0006, 16'h0FF0};
    for (int i = 0; i < 256; i++) begin
      chrow[i] = 16'($urandom_range(0, 65535));
      pal[i]   = 16'($urandom_range(0, 65535));
    end
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom_range(0, 255));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_n", pixbuf_wr_n, 1);
    chk("rst_chrow_n", chrowbuf_rd_n, 1);
    chk("rst_font_n", fontmem_rd_n, 1);
    chk("rst_pal_n", palette_rd_n, 1);
    chk("rst_wr_addr", pixbuf_wr_addr, 0);
    chk("rst_wr_data", pixbuf_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Uniform row; a second start at cycle 100 must be ignored
    setup_basic();
    start_a(4'd3);
    run_line(94, 0);
    for (int k = 0; k < 8; k++) chk("cell0_pixel", wr_log[k], cell_tbl[k]);
    for (int k = 0; k < 8; k++) chk("cell99_pixel", wr_log[792 + k], cell_tbl[k]);

    // Reset at write #300, then a clean line
    start_a(4'd3);
    run_line(0, 300);
    start_a(4'd3);
    run_line(0, 0);

    // One code per column, single leftmost fg pixel per cell
    for (int c = 0; c < 100; c++) begin
      chrow[c] = {8'h21, 8'(c)};
      font[{8'(c), 4'd5}] = 8'h80;
    end
    start_a(4'd5);
    run_line(0, 0);
    foreach (cell_tbl[i]) begin
      n = (i * 13) % 100;
      chk("onehot_fg", wr_log[8 * n], 16'h0FF0);
      chk("onehot_bg", wr_log[8 * n + 1 + (i % 7)], 16'h0006);
    end

    // Random cells, palette and glyph row
    for (int c = 0; c < 100; c++) chrow[c] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 16; i++) pal[i] = 16'($urandom_range(0, 65535));
    start_a(4'($urandom_range(0, 15)));
    run_line(0, 0);

    // Two-column instance wrapping past the top of the pixel buffer
    @(negedge clk);
    start_b    = 1'b1;
    font_row_b = 4'($urandom_range(0, 15));
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 8; k++)
        exp_b_q.push_back(exp_pix(1020, c, k, font_row_b));
    @(negedge clk);
    start_b = 1'b0;
    n = 1;
    while (pixbuf_wr_n_b !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_first_write_cycle", n, 6);
    chk("b_first_addr", pixbuf_wr_addr_b, 10'd1020);
    cnt = 0;
    while (pixbuf_wr_n_b === 1'b0 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("b_write_count", cnt, 16);
    chk("b_done", done_b, 1);
    chk("b_queue_drained", exp_b_q.size(), 0);

`ifdef RENDER_CURSOR_EN
    setup_basic();
    cursor_on  = 1'b1;
    cursor_col = 8'd5;
    start_a(4'd3);
    run_line(0, 0);
    chk("cursor_swapped", wr_log[40], 16'h0006);
    chk("cursor_swapped_b", wr_log[41], 16'h0FF0);
    chk("cursor_neighbour", wr_log[32], 16'h0FF0);
    cursor_col = 8'd200;
    start_a(4'd3);
    run_line(0, 0);
    chk("cursor_out_of_range", wr_log[40], 16'h0FF0);
    cursor_on = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
